// File: rtl/ov7670_gen_pkg.sv
// ov7670_gen_pkg: shared types and constants for the OV7670 stream generator.
//   state_t      - frame sequencer states
//   pat_t        - pattern select codes carried on i_pat_sel
//   BAR_RGB      - the eight RGB444 colour-bar values, index 0 = leftmost bar
//   PIX_BYTES    - bytes per pixel on the RGB444 byte bus
//   clog2_min1() - counter width helper that never returns zero
package ov7670_gen_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_CHECK = 2'd3
  } pat_t;

  localparam int PIX_BYTES = 2;

  // Packed so that BAR_RGB[i] is bar i; listed MSB (bar 7) first.
  localparam logic [7:0][11:0] BAR_RGB = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  // A counter for a range of 1 still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ov7670_pat_color.sv
// ov7670_pat_color: combinational test-pattern colour lookup.
//   pat_sel   in  2   pattern code (pat_t)
//   x         in  8   low bits of the pattern column
//   y         in  4   low bits of the active line
//   bar_idx   in  3   current colour bar from the running bar counter
//   solid_rgb in  12  latched solid colour
//   rgb       out 12  RGB444 colour of this pixel
module ov7670_pat_color
  import ov7670_gen_pkg::*;
(
  input  logic [1:0]  pat_sel,
  input  logic [7:0]  x,
  input  logic [3:0]  y,
  input  logic [2:0]  bar_idx,
  input  logic [11:0] solid_rgb,
  output logic [11:0] rgb
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    rgb = 12'h000;
    case (pat_t'(pat_sel))
      PAT_BARS:  rgb = BAR_RGB[bar_idx];
      PAT_GRAD:  rgb = {x[3:0], y, x[7:4]};
      PAT_SOLID: rgb = solid_rgb;
      PAT_CHECK: rgb = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
      default:   rgb = 12'h000;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: OV7670 camera emulator driving VSYNC/HREF and an RGB444
// byte stream (byte 0 = {4'h0,R}, byte 1 = {G,B}) for the capture path.
//   i_clk        in  1   byte clock
//   i_rst        in  1   synchronous active-high reset
//   i_ce         in  1   byte-rate enable; nothing moves while low
//   i_run        in  1   stream request, sampled at frame boundaries
//   i_pat_sel    in  2   pattern select, latched on entry to VSYNC
//   i_solid_rgb  in  12  solid colour, latched on entry to VSYNC
//   o_pix_byte   out 8   pixel byte, 0 whenever o_href is low
//   o_href       out 1   line valid
//   o_vsync      out 1   frame sync, active high
//   o_frame_done out 1   pulse on the byte after the last VFRONT byte
//   o_busy       out 1   high when not IDLE
// Optional macro STREAM_GEN_SCROLL_EN: adds an 8-bit frame counter and starts
// each line's pattern column at frame_cnt mod H_ACTIVE so the image scrolls.
module ov7670_stream_gen
  import ov7670_gen_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 288,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ce,
  input  logic        i_run,
  input  logic [1:0]  i_pat_sel,
  input  logic [11:0] i_solid_rgb,
  output logic [7:0]  o_pix_byte,
  output logic        o_href,
  output logic        o_vsync,
  output logic        o_frame_done,
  output logic        o_busy
);

  localparam int ACT_BYTES  = H_ACTIVE * PIX_BYTES;
  localparam int LINE_BYTES = ACT_BYTES + H_BLANK;
  localparam int LINE_MAX01 = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int LINE_MAX23 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int LINE_MAX   = (LINE_MAX01 > LINE_MAX23) ? LINE_MAX01 : LINE_MAX23;
  localparam int BAR_PIX    = H_ACTIVE / 8;

  localparam int BYTE_W = clog2_min1(LINE_BYTES);
  localparam int LINE_W = clog2_min1(LINE_MAX);
  localparam int X_W    = clog2_min1(H_ACTIVE);
  localparam int BARP_W = clog2_min1(BAR_PIX);

  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(LINE_BYTES - 1);
  localparam logic [BYTE_W-1:0] ACT_END   = BYTE_W'(ACT_BYTES);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(H_ACTIVE - 1);
  localparam logic [BARP_W-1:0] BARP_LAST = BARP_W'(BAR_PIX - 1);

  // Horizontal position of the pixel being sent: pattern column plus the
  // running colour-bar counter, which replaces an x / BAR_PIX divide.
  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [2:0]        bar_idx;
    logic [BARP_W-1:0] bar_pix;
  } pix_pos_t;

  // Advance one pixel; column and bars wrap together at H_ACTIVE.
  function automatic pix_pos_t pix_adv(input pix_pos_t p);
    pix_pos_t n;
    n   = p;
    n.x = (p.x == X_LAST) ? '0 : p.x + 1'b1;
    if (p.bar_pix == BARP_LAST) begin
      n.bar_pix = '0;
      n.bar_idx = p.bar_idx + 1'b1;
    end else begin
      n.bar_pix = p.bar_pix + 1'b1;
    end
    return n;
  endfunction

  function automatic logic [LINE_W-1:0] last_line(input state_t s);
    case (s)
      VSYNC:   return LINE_W'(V_SYNC - 1);
      VBACK:   return LINE_W'(V_BACK - 1);
      ACTIVE:  return LINE_W'(V_ACTIVE - 1);
      VFRONT:  return LINE_W'(V_FRONT - 1);
      default: return '0;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [BYTE_W-1:0]  byte_q, byte_d;
  logic [LINE_W-1:0]  line_q, line_d;
  pix_pos_t           pos_q, pos_d;
  pix_pos_t           scroll_off;
  logic               frame_end;
  logic [1:0]         pat_q;
  logic [11:0]        solid_q;
  logic [11:0]        rgb;
  logic               href_d;

  // ---------------------------------------------------------------------------
  // Scroll offset: start-of-line pixel position, one pixel further per frame.
  // ---------------------------------------------------------------------------
`ifdef STREAM_GEN_SCROLL_EN
  logic [7:0] frame_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt  <= '0;
      scroll_off <= '0;
    end else if (i_ce && frame_end) begin
      frame_cnt <= frame_cnt + 1'b1;
      // Restart the offset when the 8-bit count wraps so it stays equal to
      // frame_cnt mod H_ACTIVE for any H_ACTIVE.
      if (frame_cnt == 8'hFF) scroll_off <= '0;
      else                    scroll_off <= pix_adv(scroll_off);
    end
  end
`else
  assign scroll_off = '0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and counter logic. Outputs are registered from these next
  // values so every output describes the byte the counters now point at.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    line_d    = line_q;
    pos_d     = pos_q;
    frame_end = 1'b0;
    if (i_ce) begin
      if (state_q == IDLE) begin
        byte_d = '0;
        line_d = '0;
        pos_d  = scroll_off;
        if (i_run) state_d = VSYNC;
      end else if (byte_q == BYTE_LAST) begin
        byte_d = '0;
        pos_d  = scroll_off;
        if (line_q == last_line(state_q)) begin
          line_d = '0;
          case (state_q)
            VSYNC:   state_d = VBACK;
            VBACK:   state_d = ACTIVE;
            ACTIVE:  state_d = VFRONT;
            VFRONT: begin
              frame_end = 1'b1;
              state_d   = i_run ? VSYNC : IDLE;
            end
            default: state_d = IDLE;
          endcase
        end else begin
          line_d = line_q + 1'b1;
        end
      end else begin
        byte_d = byte_q + 1'b1;
        // Leaving the second byte of a pixel moves on to the next pixel.
        if (byte_q[0]) pos_d = pix_adv(pos_q);
      end
    end
  end

  assign href_d = (state_d == ACTIVE) && (byte_d < ACT_END);

  ov7670_pat_color u_pat_color (
    .pat_sel   (pat_q),
    .x         (8'(pos_d.x)),
    .y         (4'(line_d)),
    .bar_idx   (pos_d.bar_idx),
    .solid_rgb (solid_q),
    .rgb       (rgb)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      byte_q       <= '0;
      line_q       <= '0;
      pos_q        <= '0;
      pat_q        <= '0;
      solid_q      <= '0;
      o_pix_byte   <= '0;
      o_href       <= 1'b0;
      o_vsync      <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
    end else if (i_ce) begin
      state_q <= state_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
      pos_q   <= pos_d;
      if (state_d == VSYNC && state_q != VSYNC) begin
        pat_q   <= i_pat_sel;
        solid_q <= i_solid_rgb;
      end
      o_href       <= href_d;
      o_pix_byte   <= !href_d ? 8'h00 : (byte_d[0] ? rgb[7:0] : {4'h0, rgb[11:8]});
      o_vsync      <= (state_d == VSYNC);
      o_frame_done <= frame_end;
      o_busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb_ov7670_stream_gen: self-checking bench for ov7670_stream_gen with a small
// frame (8x2 active, 20-byte lines, 100-byte frames). A frame-position model
// predicts every output each cycle; directed checks pin framing, bars, latch
// timing, stop, clock-enable gating, reset and the scroll start column.
module tb_ov7670_stream_gen;

  localparam int H_ACTIVE = 8;
  localparam int V_ACTIVE = 2;
  localparam int H_BLANK  = 4;
  localparam int V_SYNC   = 1;
  localparam int V_BACK   = 1;
  localparam int V_FRONT  = 1;
  localparam int LINE_B   = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_B  = LINE_B * (V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
`ifdef STREAM_GEN_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        ce;
  logic        run;
  logic [1:0]  pat_sel;
  logic [11:0] solid_rgb;
  logic [7:0]  pix_byte;
  logic        href, vsync, frame_done, busy;

  ov7670_stream_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .V_FRONT  (V_FRONT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ce         (ce),
    .i_run        (run),
    .i_pat_sel    (pat_sel),
    .i_solid_rgb  (solid_rgb),
    .o_pix_byte   (pix_byte),
    .o_href       (href),
    .o_vsync      (vsync),
    .o_frame_done (frame_done),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_done && n < 3 * FRAME_B);
    check("frame_done_seen", frame_done, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Model: a frame is just a byte position 0..FRAME_B-1; all outputs follow
  // from that position, the frame number and the patterns latched at start.
  // ---------------------------------------------------------------------------
  logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};
  bit          m_busy  = 1'b0;
  bit          m_done  = 1'b0;
  int          m_t     = 0;
  int          m_frame = 0;
  logic [1:0]  m_pat   = '0;
  logic [11:0] m_solid = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_t = 0; m_frame = 0;
    end else if (ce) begin
      if (!m_busy) begin
        m_done = 1'b0;
        if (run) begin
          m_busy = 1'b1; m_t = 0; m_pat = pat_sel; m_solid = solid_rgb;
        end
      end else if (m_t == FRAME_B - 1) begin
        m_done = 1'b1;
        m_frame++;
        if (run) begin
          m_t = 0; m_pat = pat_sel; m_solid = solid_rgb;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_t++;
        m_done = 1'b0;
      end
    end
  end

  function automatic logic [11:0] model_out();
    logic [7:0]  pb, xv;
    logic [3:0]  yv;
    logic [11:0] c;
    logic        hr, vs;
    int          ln, b, p, x, y;
    pb = 8'h00; hr = 1'b0; vs = 1'b0; c = 12'h000;
    if (m_busy) begin
      ln = m_t / LINE_B;
      b  = m_t % LINE_B;
      vs = (ln < V_SYNC);
      if (ln >= V_SYNC + V_BACK && ln < V_SYNC + V_BACK + V_ACTIVE && b < 2 * H_ACTIVE) begin
        hr = 1'b1;
        y  = ln - (V_SYNC + V_BACK);
        p  = b / 2;
        x  = SCROLL ? (((m_frame % 256) % H_ACTIVE) + p) % H_ACTIVE : p;
        xv = 8'(x);
        yv = 4'(y);
        case (m_pat)
          2'd0:    c = bar_tab[x / (H_ACTIVE / 8)];
          2'd1:    c = {xv[3:0], yv, xv[7:4]};
          2'd2:    c = m_solid;
          default: c = (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
        endcase
        pb = (b % 2 == 0) ? {4'h0, c[11:8]} : c[7:0];
      end
    end
    return {pb, hr, vs, m_done, m_busy};
  endfunction

  always @(negedge clk) begin
    if (chk_en) check("stream", {pix_byte, href, vsync, frame_done, busy}, model_out());
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  logic [7:0]  bars_exp [20] = '{8'h0F, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hF0,
                                 8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00,
                                 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0]  pb_r [0:204];
  logic        hr_r [0:204];
  logic        vs_r [0:204];
  logic        fd_r [0:204];
  logic        hr_c [0:299];
  logic [11:0] v_c  [0:299];

  initial begin
    int n, cnt, r1, r2, run1, hold_bad;
    rst = 1'b1; ce = 1'b1; run = 1'b0; pat_sel = 2'd0; solid_rgb = 12'h000;
    tick();
    chk_en = 1'b1;
    skip(2);
    check("reset_outputs", {pix_byte, href, vsync, frame_done, busy}, 12'h000);
    rst = 1'b0;

    // Framing and colour bars.
    run = 1'b1; pat_sel = 2'd0;
    n = 0;
    do begin tick(); n++; end while (!vsync && n < 10);
    check("vsync_start", vsync, 1);
    for (int i = 0; i < 205; i++) begin
      pb_r[i] = pix_byte; hr_r[i] = href; vs_r[i] = vsync; fd_r[i] = frame_done;
      tick();
    end
    cnt = 0;
    for (int i = 0; i < 100; i++) if (vs_r[i]) cnt++;
    check("vsync_cycles", cnt, 20);
    cnt = 0;
    for (int i = 0; i < 100; i++) if (hr_r[i]) cnt++;
    check("href_cycles_frame", cnt, 32);
    r1 = -1;
    for (int i = 0; i < 100; i++) if (hr_r[i] && r1 < 0) r1 = i;
    check("href_first_byte", r1, 40);
    run1 = 0;
    for (int i = 40; i < 60 && hr_r[i]; i++) run1++;
    check("href_line0_len", run1, 16);
    run1 = 0;
    for (int i = 60; i < 80 && hr_r[i]; i++) run1++;
    check("href_line1_len", run1, 16);
    r2 = -1;
    for (int i = 57; i < 100; i++) if (hr_r[i] && !hr_r[i-1] && r2 < 0) r2 = i;
    check("line_length", r2 - 40, 20);
    check("frame_done_at_100", fd_r[100], 1);
    check("frame_done_at_200", fd_r[200], 1);
    cnt = 0;
    for (int i = 0; i < 205; i++) if (fd_r[i]) cnt++;
    check("frame_done_count", cnt, 2);
    for (int k = 0; k < 20; k++) check($sformatf("bars_byte%0d", k), pb_r[40+k], bars_exp[k]);

    // Solid colour and frame-boundary latching.
    pat_sel = 2'd2; solid_rgb = 12'hA5C;
    wait_done(n);
    skip(40);
    check("solid_r", pix_byte, 8'h0A);
    tick();
    check("solid_gb", pix_byte, 8'h5C);
    solid_rgb = 12'h123;
    skip(19);
    check("solid_held_midframe", pix_byte, 8'h0A);
    wait_done(n);
    skip(40);
    check("solid_new_r", pix_byte, 8'h01);
    tick();
    check("solid_new_gb", pix_byte, 8'h23);

    // Stop mid-ACTIVE: the frame completes, then the stream goes idle.
    run = 1'b0;
    wait_done(n);
    check("stop_done_latency", n, 59);
    check("stop_busy_low", {busy, vsync, href}, 3'b000);
    skip(30);
    check("idle_outputs", {pix_byte, href, vsync, frame_done, busy}, 12'h000);

    // Clock-enable gating at half rate, checker pattern.
    pat_sel = 2'd3; run = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ce = (i % 2 == 0);
      tick();
      hr_c[i] = href;
      v_c[i]  = {pix_byte, href, vsync, frame_done, busy};
    end
    hold_bad = 0;
    for (int i = 1; i < 300; i += 2) if (v_c[i] !== v_c[i-1]) hold_bad++;
    check("ce_hold_violations", hold_bad, 0);
    r1 = -1; r2 = -1;
    for (int i = 1; i < 300; i++) begin
      if (hr_c[i] && !hr_c[i-1]) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
    end
    check("ce_line_clocks", r2 - r1, 40);
    run1 = 0;
    for (int i = (r1 < 0 ? 0 : r1); i < 300 && hr_c[i]; i++) run1++;
    check("ce_href_clocks", run1, 32);

    // Reset mid-line, then restart with the gradient pattern.
    ce = 1'b1; pat_sel = 2'd1;
    skip(7);
    rst = 1'b1;
    tick();
    check("reset_mid_line", {pix_byte, href, vsync, frame_done, busy}, 12'h000);
    tick();
    rst = 1'b0;
    tick();
    check("start_latency", {vsync, busy}, 2'b11);

    // Second frame after reset: scroll shifts column 0 to x=1.
    wait_done(n);
    skip(40);
    check("frame1_pix0_r", pix_byte, SCROLL ? 8'h01 : 8'h00);
    tick();
    check("frame1_pix0_gb", pix_byte, 8'h00);

    skip(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
